// File: rtl/flash_responder_pkg.sv
// rtl/flash_responder_pkg.sv - shared types and constants for the flash responder
package flash_responder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [DATA_W-1:0] OOR_DATA = 32'h0000_0000;

endpackage

// File: rtl/be_ram.sv
// rtl/be_ram.sv - single-port byte-enabled RAM with one-cycle registered read
module be_ram
    import flash_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [BE_W-1:0]       i_be,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    // Byte-masked write and enabled registered read; contents are never reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/flash_responder.sv
// rtl/flash_responder.sv - Avalon-MM style flash stand-in with wait states and pipelined reads
module flash_responder
    import flash_responder_pkg::*;
#(
    parameter int DEPTH_LOG2   = 8,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flash_mem_read,
    input  logic              flash_mem_write,
    input  logic [ADDR_W-1:0] flash_mem_address,
    input  logic [DATA_W-1:0] flash_mem_writedata,
    input  logic [BE_W-1:0]   flash_mem_byteenable,
    output logic              flash_mem_waitrequest,
    output logic [DATA_W-1:0] flash_mem_readdata,
    output logic              flash_mem_readdatavalid,
    output logic              range_err
);

    localparam int          PL      = READ_LATENCY - 1;
    localparam logic [3:0]  WC_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0]  MAXP    = 4'(MAX_PENDING);

    state_t              r_state, w_state_n;
    logic [3:0]          r_wcnt, w_wcnt_n;
    logic [3:0]          r_pending;
    logic                w_cmd, w_oor, w_acc_rd, w_acc_wr, w_waitreq;
    logic                r_v1, r_oor1, r_rerr;
    logic [DATA_W-1:0]   w_ram_rdata, w_d1;
    logic [PL-1:0]       r_pv;
    logic [DATA_W-1:0]   r_pd [PL];

    assign w_cmd = flash_mem_read | flash_mem_write;
    assign w_oor = (flash_mem_address >> DEPTH_LOG2) != '0;

    // Command FSM state and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_wcnt  <= w_wcnt_n;
        end
    end

    // Next state, wait countdown, and the single accept cycle with waitrequest low
    always_comb begin
        w_state_n = r_state;
        w_wcnt_n  = r_wcnt;
        w_waitreq = 1'b1;
        w_acc_rd  = 1'b0;
        w_acc_wr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd) begin
                    w_state_n = WAIT;
                    w_wcnt_n  = WC_INIT;
                end
            end
            WAIT: begin
                if (!w_cmd) begin
                    w_state_n = IDLE;
                end else if (r_wcnt != 4'd0) begin
                    w_wcnt_n = r_wcnt - 4'd1;
                end else if (flash_mem_write || (r_pending < MAXP)) begin
                    w_waitreq = 1'b0;
                    w_acc_rd  = flash_mem_read;
                    w_acc_wr  = flash_mem_write;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign flash_mem_waitrequest = w_waitreq;

    be_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .i_clk   (clk),
        .i_we    (w_acc_wr & ~w_oor),
        .i_be    (flash_mem_byteenable),
        .i_re    (w_acc_rd),
        .i_addr  (flash_mem_address[DEPTH_LOG2-1:0]),
        .i_wdata (flash_mem_writedata),
        .o_rdata (w_ram_rdata)
    );

    // Outstanding-read count; simultaneous accept and return cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            case ({w_acc_rd, flash_mem_readdatavalid})
                2'b10:   r_pending <= r_pending + 4'd1;
                2'b01:   r_pending <= r_pending - 4'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // First pipeline stage runs alongside the RAM read and remembers out-of-range reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_oor1 <= 1'b0;
        end else begin
            r_v1   <= w_acc_rd;
            r_oor1 <= w_acc_rd & w_oor;
        end
    end

    assign w_d1 = r_oor1 ? OOR_DATA : w_ram_rdata;

    // Remaining latency stages; data only moves with a valid so the last stage holds readdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < PL; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= r_v1;
            if (r_v1) begin
                r_pd[0] <= w_d1;
            end
            for (int i = 1; i < PL; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end
        end
    end

    assign flash_mem_readdatavalid = r_pv[PL-1];
    assign flash_mem_readdata      = r_pd[PL-1];

    // Sticky flag for any accepted command outside the RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rerr <= 1'b0;
        end else if ((w_acc_rd | w_acc_wr) & w_oor) begin
            r_rerr <= 1'b1;
        end
    end

    assign range_err = r_rerr;

endmodule

// File: doc/flash_responder.md
# flash_responder

Avalon-MM style read/write responder that stands in for the flash controller on the `flash_mem_*` interface. It serves 32-bit words from an internal byte-enabled RAM with programmable wait states and pipelined read latency. It lets flash-reading masters (such as the sample loader) be simulated and run on-chip without the flash IP.

## Interface
Parameters:
- `DEPTH_LOG2`, 8: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, 2: cycles between command first seen and acceptance; legal range 1..15.
- `READ_LATENCY`, 3: accept-to-readdatavalid delay in cycles; legal range 2..8.
- `MAX_PENDING`, 4: maximum reads accepted but not yet returned; legal range 1..8.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flash_mem_read`  in  1  read command.
- `flash_mem_write`  in  1  write command; never asserted together with read.
- `flash_mem_address`  in  23  word address.
- `flash_mem_writedata`  in  32  write data.
- `flash_mem_byteenable`  in  4  per-byte write enable; ignored for reads.
- `flash_mem_waitrequest`  out  1  0 only in the cycle a command is accepted.
- `flash_mem_readdata`  out  32  read data; qualified by readdatavalid.
- `flash_mem_readdatavalid`  out  1  one-cycle pulse per returned read.
- `range_err`  out  1  sticky; set by any accepted command with `address[22:DEPTH_LOG2] != 0`.

## Operation
- Command FSM has two states, IDLE and WAIT.
- IDLE:
  - waitrequest is 1.
  - If read or write is high, go to WAIT with `wcnt = WAIT_CYCLES-1`.
- WAIT:
  - If the command is dropped, return to IDLE with no effect.
  - If `wcnt != 0`, decrement.
  - If `wcnt == 0` and (write, or read with `pending < MAX_PENDING`): waitrequest=0 combinationally, the command is accepted, and the FSM goes to IDLE.
  - A read with `pending == MAX_PENDING` stays in WAIT with waitrequest=1 until a return frees a slot.
- Accepted write: bytes with `byteenable[i]=1` are written at `address[DEPTH_LOG2-1:0]`; other bytes are unchanged.
- Accepted read:
  - Address enters a READ_LATENCY-deep valid/address pipeline.
  - Returns complete in order.
  - A read returns RAM contents as of its accept cycle.
- Out-of-range command:
  - Read returns 32'h0000_0000.
  - Write is dropped.
  - Both set `range_err`.
- `pending` is +1 on read accept and −1 on readdatavalid. When both happen in the same cycle it is unchanged. The accept check uses the pre-update value.
- readdata holds its last returned value between pulses.
- Reset values:
  - waitrequest 1, readdatavalid 0, readdata 0, range_err 0.
  - FSM IDLE, pending 0, pipeline empty.
  - RAM contents are not reset and are retained across reset.
- Reset mid-read discards all in-flight reads; no readdatavalid pulse appears after reset deasserts until a new read is accepted.

## Timing
- Command first seen in IDLE at cycle t is accepted at t+WAIT_CYCLES when not throttled.
- Back-to-back commands: at most one accept every WAIT_CYCLES+1 cycles.
- Read accepted at cycle a: readdatavalid=1 with data at a+READ_LATENCY, for exactly one cycle.
- Write accepted at cycle a is visible to any read accepted at a+1 or later.
- A master holding read high after acceptance issues a new read; there is no implicit de-duplication.
- waitrequest is combinational from FSM state, wcnt, pending and the command inputs. All other outputs are registered.

## Structure
- Package `flash_responder_pkg`:
  - state enum `{IDLE, WAIT}`
  - `ADDR_W = 23`
  - `DATA_W = 32`
  - `BE_W = 4`
  - `OOR_DATA = 32'h0`
- Sub-module `be_ram`: single-port synchronous RAM with per-byte write enables and 1-cycle read latency, inferred as block RAM.
- The remaining READ_LATENCY-1 stages are a shift register in `flash_responder`.

## Test plan
- Reset, write 32'hA5A5_1234 to address 5 (be=4'hF), then read address 5 with WAIT_CYCLES=2, READ_LATENCY=3 -> waitrequest low 2 cycles after the command appears; readdata=32'hA5A5_1234 with readdatavalid 3 cycles after accept.
- Write 32'hFFFF_FFFF to address 9 with be=4'hF, then 32'h0000_0000 with be=4'b0101, then read address 9 -> 32'hFF00_FF00.
- MAX_PENDING=1, READ_LATENCY=4, two back-to-back reads -> second read held in WAIT with waitrequest=1 until the first readdatavalid; returns in order; pending never exceeds 1.
- Read address 23'h100 with DEPTH_LOG2=8 -> readdata=0, range_err=1 and staying 1; a write to 23'h100 leaves word 0 unchanged.
- Assert rst_n low one cycle after a read is accepted, release, wait 10 cycles -> no readdatavalid; a previously written word reads back intact.
- Drive 256 sequential reads as the sample loader does -> 256 readdatavalid pulses with matching data, none lost or duplicated.
